dlfloat_div_iter: RTL and testbench
===================================

// Module: dlfloat_div_iter
// PURPOSE
//  Parametrised, multi-cycle DLfloat divider; successor to the single-cycle 16-bit divide unit in the FPU.
//  Accepts one a/b operand pair over a valid/ready handshake and runs a radix-2 restoring mantissa division.
//  Returns a widened result (extra guard bits) plus IEEE-style exception flags.
//  Sits in the FPU execute stage beside add/mul; the opcode selects divide; other opcodes complete as no-ops.
// PARAMETERS
//  EXP_W    6        exponent field width; bias = 2**(EXP_W-1)-1 (31 by default)
//  MAN_W    9        stored input mantissa width (hidden 1 implied)
//  GRD_W    4        extra quotient bits on the output mantissa; output mantissa = MAN_W+GRD_W
//  OP_DIV   4'b0011  opcode value that selects divide
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              synchronous reset, active-high
//  in_valid   in   1              operands/opcode valid
//  in_ready   out  1              high only in IDLE
//  in_op      in   4              opcode; divide iff == OP_DIV
//  in_a       in   1+EXP_W+MAN_W  dividend {s,e,m}
//  in_b       in   1+EXP_W+MAN_W  divisor {s,e,m}
//  out_valid  out  1              result valid; held until out_ready
//  out_ready  in   1              consumer accepts result
//  out_c      out  1+EXP_W+MAN_W+GRD_W  {s,e,m}; 20 bits by default
//  out_flags  out  5              {invalid, inexact, overflow, underflow, div_by_zero}
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state=IDLE; in_ready=1; out_valid=0; out_c=0; out_flags=0. Reset mid-operation drops the in-flight op; no result is produced.
//  Accept: in_valid&&in_ready at an edge. Operands and opcode are registered; in_ready drops next cycle.
//  FSM: IDLE -> (accept) CLASSIFY -> SPECIAL | ITER; ITER runs Q_W=MAN_W+GRD_W+2 cycles -> NORM -> DONE;
//    SPECIAL -> DONE. In DONE: out_valid=1; on out_ready -> IDLE (in_ready=1 the cycle after the pop).
//  Latency (accept edge -> out_valid): special/non-div = 2 cycles; normal = Q_W+3 (18 by default).
//  While out_valid && !out_ready: out_c and out_flags are held stable. Operands do not change until the next accept.
//  in_op!=OP_DIV: takes the SPECIAL path; out_c=0 and flags=0.
//  Classes: zero = e==0 && m==0 (either sign); inf = e==all-ones && m==0; NaN = e==all-ones && m!=0.
//  Result encodings:
//    NaN = {0, all-ones, 1, 0...}
//    inf = {s, all-ones, 0}
//    zero = {s, 0, 0}
//  Sign s = sa^sb for everything except NaN.
//  Special priority (first match wins):
//    1. either input NaN, 0/0 or inf/inf -> NaN, invalid
//    2. x/0 -> inf, div_by_zero
//    3. inf/x -> inf, no flags
//    4. x/inf -> zero
//    5. 0/x -> zero
//  Normal datapath:
//    - q = {1,ma}<<(Q_W-1) / {1,mb}, restoring, 1 quotient bit per cycle, MSB first; remainder width MAN_W+2.
//    - Exponent is computed signed, EXP_W+2 bits wide: e = ea - eb + bias.
//    - If q[Q_W-1]=1: take mantissa bits q[Q_W-2 -: MAN_W+GRD_W].
//      Else: shift left 1 and e = e-1.
//    - Rounding is truncation. inexact = (final remainder != 0) | (dropped q LSB != 0).
//    - e <= 0 -> zero result, underflow (+inexact).
//    - e >= all-ones -> inf, overflow (+inexact).
//    - Otherwise {s, e[EXP_W-1:0], mant}.
//  Flags reflect only the current result; they clear when the result is popped.
// STRUCTURE
//  Shared package dlfloat_pkg holds:
//    - field widths and bias function
//    - flag bit indices (FLG_INV=4..FLG_DZ=0)
//    - special encodings (NaN/inf/zero builders)
//    - state enum {IDLE, CLASSIFY, SPECIAL, ITER, NORM, DONE}
//    - classify function
//  Sub-module dlfloat_div_mant_core: restoring iterative mantissa divider.
//    - Interface: start/busy/done, quotient, remainder_nz.
//    - Parametrised by MAN_W and Q_W.
//    - Top level keeps the FSM, exponent path, specials and output register.
// TESTING (default params; out_c is 20 bits)
//  1. 0x3E00/0x4000 (1.0/2.0) -> out_c=0x3C000, flags=5'b00000, out_valid 18 cycles after accept.
//  2. 0x3E00/0x4100 (1.0/3.0) -> out_c=0x3AAAA, flags=5'b01000 (inexact).
//  3. Specials:
//     - 0x3E00/0x0000 -> 0x7E000, flags=5'b00001
//     - 0x8000/0x0000 -> 0x7F000, flags=5'b10000
//     - 0x7E00/0x7E00 -> 0x7F000, flags=5'b10000
//     - each out_valid 2 cycles after accept
//  4. Range limits:
//     - 0x7C00/0x0200 (e=62 / e=1) -> 0x7E000, flags=5'b01100 (overflow)
//     - 0x0200/0x7C00 -> 0x00000, flags=5'b01010 (underflow)
//  5. Backpressure: hold out_ready=0 for 10 cycles -> out_c/out_flags stable, in_ready=0.
//     Then pulse out_ready -> next accept possible 1 cycle later. Also: in_op=4'b0001 -> 0x00000, flags 0.
//  6. Assert rst at ITER cycle 5 -> next cycle out_valid=0, in_ready=1, out_c=0.
//     A new op after reset returns a correct result.

Source files
------------

// File: rtl/dlfloat_pkg.sv
// ============================================================================
// Module   : dlfloat_pkg
// Brief    : Shared DLfloat widths, flag indices, FSM states, class/encoding helpers
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dlfloat_pkg;

    localparam int EXP_W_DEF = 6;
    localparam int MAN_W_DEF = 9;
    localparam int GRD_W_DEF = 4;

    localparam int FLG_W   = 5;
    localparam int FLG_INV = 4;
    localparam int FLG_INX = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_DZ  = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLASSIFY = 3'd1,
        ST_SPECIAL  = 3'd2,
        ST_ITER     = 3'd3,
        ST_NORM     = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } cls_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Non-zero mantissa with zero exponent is treated as a normal operand
    function automatic cls_t classify(input logic e_zero, input logic e_ones, input logic m_zero);
        if (e_ones)
            return m_zero ? CLS_INF : CLS_NAN;
        if (e_zero && m_zero)
            return CLS_ZERO;
        return CLS_NORMAL;
    endfunction

    // Builders return a right-aligned {s, e, m} word; callers truncate to their width
    function automatic logic [63:0] enc_nan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic [63:0] enc_inf(input logic s, input int exp_w, input int man_w);
        return ({63'd0, s} << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd1) << man_w);
    endfunction

    function automatic logic [63:0] enc_zero(input logic s, input int exp_w, input int man_w);
        return {63'd0, s} << (exp_w + man_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dlfloat_div_iter_if.sv
// ============================================================================
// Module   : dlfloat_div_iter_if
// Brief    : Operand/result handshake bundle for the iterative DLfloat divider
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface dlfloat_div_iter_if
    import dlfloat_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 20
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [IN_W-1:0]  in_a;
    logic [IN_W-1:0]  in_b;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_c;
    logic [FLG_W-1:0] out_flags;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_c, out_flags
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_c, out_flags
    );
endinterface

`default_nettype wire

// File: rtl/dlfloat_div_mant_core.sv
// ============================================================================
// Module   : dlfloat_div_mant_core
// Brief    : Radix-2 restoring mantissa divider, one quotient bit per cycle, MSB first
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dlfloat_div_mant_core #(
    parameter int MAN_W = 9,
    parameter int Q_W   = 15
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic [MAN_W:0]   dividend,
    input  wire logic [MAN_W:0]   divisor,
    output logic                  busy,
    output logic                  done,
    output logic [Q_W-1:0]        quotient,
    output logic                  remainder_nz
);

    localparam int c_rem_w = MAN_W + 2;
    localparam int c_cnt_w = $clog2(Q_W + 1);

    logic [c_rem_w-1:0] r_rem;
    logic [MAN_W:0]     r_div;
    logic [Q_W-1:0]     r_quo;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    logic               w_ge;
    logic [c_rem_w-1:0] w_diff;

    // Partial remainder stays below the divisor, so doubling it always fits in MAN_W+2 bits
    assign w_ge   = (r_rem >= {1'b0, r_div});
    assign w_diff = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem  <= {1'b0, dividend};
                r_div  <= divisor;
                r_quo  <= '0;
                r_cnt  <= c_cnt_w'(Q_W);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_quo <= {r_quo[Q_W-2:0], w_ge};
                r_rem <= w_diff << 1;
                r_cnt <= r_cnt - c_cnt_w'(1);
                if (r_cnt == c_cnt_w'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign quotient     = r_quo;
    assign remainder_nz = |r_rem;

endmodule

`default_nettype wire

// File: rtl/dlfloat_div_iter.sv
// ============================================================================
// Module   : dlfloat_div_iter
// Brief    : Multi-cycle DLfloat divider with guard-bit output and exception flags
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dlfloat_div_iter
    import dlfloat_pkg::*;
#(
    parameter int         EXP_W  = EXP_W_DEF,
    parameter int         MAN_W  = MAN_W_DEF,
    parameter int         GRD_W  = GRD_W_DEF,
    parameter logic [3:0] OP_DIV = 4'b0011
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dlfloat_div_iter_if.slave  bus
);

    localparam int c_in_w  = 1 + EXP_W + MAN_W;
    localparam int c_om_w  = MAN_W + GRD_W;
    localparam int c_out_w = 1 + EXP_W + c_om_w;
    localparam int c_q_w   = c_om_w + 2;
    localparam int c_ew    = EXP_W + 2;
    localparam int c_bias  = bias(EXP_W);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_op;
    logic [c_in_w-1:0]   r_a;
    logic [c_in_w-1:0]   r_b;
    logic [c_out_w-1:0]  r_out_c;
    logic [FLG_W-1:0]    r_out_flags;

    logic                w_sa, w_sb, w_s;
    logic [EXP_W-1:0]    w_ea, w_eb;
    logic [MAN_W-1:0]    w_ma, w_mb;
    cls_t                w_cls_a, w_cls_b;
    logic                w_is_div;
    logic                w_special;
    logic [c_out_w-1:0]  w_spec_c;
    logic [FLG_W-1:0]    w_spec_flags;

    logic                w_core_start, w_core_busy, w_core_done, w_core_rem_nz;
    logic [c_q_w-1:0]    w_core_q;

    logic                w_q_top;
    logic [c_om_w-1:0]   w_mant;
    logic [c_ew-1:0]     w_exp;
    logic                w_inexact, w_e_low, w_e_high;
    logic [c_out_w-1:0]  w_norm_c;
    logic [FLG_W-1:0]    w_norm_flags;

    assign w_sa     = r_a[c_in_w-1];
    assign w_sb     = r_b[c_in_w-1];
    assign w_s      = w_sa ^ w_sb;
    assign w_ea     = r_a[c_in_w-2 -: EXP_W];
    assign w_eb     = r_b[c_in_w-2 -: EXP_W];
    assign w_ma     = r_a[MAN_W-1:0];
    assign w_mb     = r_b[MAN_W-1:0];
    assign w_cls_a  = classify(w_ea == '0, w_ea == '1, w_ma == '0);
    assign w_cls_b  = classify(w_eb == '0, w_eb == '1, w_mb == '0);
    assign w_is_div = (r_op == OP_DIV);

    // Special-case resolution; ordering of the chain is the priority order
    always_comb begin
        w_spec_c     = '0;
        w_spec_flags = '0;
        w_special    = 1'b1;
        if (!w_is_div) begin
            w_special = 1'b1;
        end else if (w_cls_a == CLS_NAN || w_cls_b == CLS_NAN ||
                     (w_cls_a == CLS_ZERO && w_cls_b == CLS_ZERO) ||
                     (w_cls_a == CLS_INF  && w_cls_b == CLS_INF)) begin
            w_spec_c              = c_out_w'(enc_nan(EXP_W, c_om_w));
            w_spec_flags[FLG_INV] = 1'b1;
        end else if (w_cls_b == CLS_ZERO) begin
            w_spec_c             = c_out_w'(enc_inf(w_s, EXP_W, c_om_w));
            w_spec_flags[FLG_DZ] = 1'b1;
        end else if (w_cls_a == CLS_INF) begin
            w_spec_c = c_out_w'(enc_inf(w_s, EXP_W, c_om_w));
        end else if (w_cls_b == CLS_INF || w_cls_a == CLS_ZERO) begin
            w_spec_c = c_out_w'(enc_zero(w_s, EXP_W, c_om_w));
        end else begin
            w_special = 1'b0;
        end
    end

    dlfloat_div_mant_core #(
        .MAN_W (MAN_W),
        .Q_W   (c_q_w)
    ) u_mant_core (
        .clk          (clk),
        .rst          (rst),
        .start        (w_core_start),
        .dividend     ({1'b1, w_ma}),
        .divisor      ({1'b1, w_mb}),
        .busy         (w_core_busy),
        .done         (w_core_done),
        .quotient     (w_core_q),
        .remainder_nz (w_core_rem_nz)
    );

    // Quotient lies in [2^(Q_W-2), 2^Q_W); a clear MSB costs one exponent step
    assign w_q_top   = w_core_q[c_q_w-1];
    assign w_mant    = w_q_top ? w_core_q[c_q_w-2 -: c_om_w] : w_core_q[c_q_w-3 -: c_om_w];
    assign w_exp     = {2'b00, w_ea} - {2'b00, w_eb} + c_bias[c_ew-1:0]
                     - {{(c_ew-1){1'b0}}, ~w_q_top};
    assign w_inexact = w_core_rem_nz | (w_q_top & w_core_q[0]);
    assign w_e_low   = w_exp[c_ew-1] || (w_exp == '0);
    assign w_e_high  = !w_exp[c_ew-1] && (w_exp >= {2'b00, {EXP_W{1'b1}}});

    always_comb begin
        w_norm_c     = {w_s, w_exp[EXP_W-1:0], w_mant};
        w_norm_flags = '0;
        w_norm_flags[FLG_INX] = w_inexact;
        if (w_e_low) begin
            w_norm_c              = c_out_w'(enc_zero(w_s, EXP_W, c_om_w));
            w_norm_flags[FLG_UNF] = 1'b1;
            w_norm_flags[FLG_INX] = 1'b1;
        end else if (w_e_high) begin
            w_norm_c              = c_out_w'(enc_inf(w_s, EXP_W, c_om_w));
            w_norm_flags[FLG_OVF] = 1'b1;
            w_norm_flags[FLG_INX] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_core_start = 1'b0;
        case (r_state)
            ST_IDLE:     if (bus.in_valid) w_state_nxt = ST_CLASSIFY;
            ST_CLASSIFY: begin
                if (w_special) begin
                    w_state_nxt = ST_SPECIAL;
                end else begin
                    w_state_nxt  = ST_ITER;
                    w_core_start = 1'b1;
                end
            end
            ST_SPECIAL:  w_state_nxt = ST_DONE;
            ST_ITER:     if (w_core_done && !w_core_busy) w_state_nxt = ST_NORM;
            ST_NORM:     w_state_nxt = ST_DONE;
            ST_DONE:     if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= '0;
            r_a  <= '0;
            r_b  <= '0;
        end else if (r_state == ST_IDLE && bus.in_valid) begin
            r_op <= bus.in_op;
            r_a  <= bus.in_a;
            r_b  <= bus.in_b;
        end
    end

    // Result register: loaded on entry to DONE, cleared when the consumer pops it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_c     <= '0;
            r_out_flags <= '0;
        end else begin
            case (r_state)
                ST_SPECIAL: begin
                    r_out_c     <= w_spec_c;
                    r_out_flags <= w_spec_flags;
                end
                ST_NORM: begin
                    r_out_c     <= w_norm_c;
                    r_out_flags <= w_norm_flags;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_c     <= '0;
                        r_out_flags <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_c     = r_out_c;
    assign bus.out_flags = r_out_flags;

endmodule

`default_nettype wire

// File: tb/tb_dlfloat_div_iter.sv
// ============================================================================
// Module   : tb_dlfloat_div_iter
// Brief    : Directed self-checking bench for dlfloat_div_iter (default widths)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dlfloat_div_iter;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    dlfloat_div_iter_if #(.IN_W(16), .OUT_W(20)) ifc ();

    dlfloat_div_iter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Issue one operation, measure accept-to-out_valid latency, optionally pop it
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input bit pop, output int lat,
                         output logic [31:0] c, output logic [31:0] f);
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_op    = op;
        ifc.in_a     = a;
        ifc.in_b     = b;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        lat = 0;
        while (!ifc.out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        c = {12'd0, ifc.out_c};
        f = {27'd0, ifc.out_flags};
        if (pop) begin
            @(negedge clk);
            ifc.out_ready = 1'b1;
            @(posedge clk);
            #1;
            ifc.out_ready = 1'b0;
        end
    endtask

    task automatic vec(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp_c,
                       input logic [31:0] exp_f, input int exp_lat);
        int          lat;
        logic [31:0] c, f;
        do_op(op, a, b, 1'b1, lat, c, f);
        check({tag, "_c"}, c, exp_c);
        check({tag, "_flags"}, f, exp_f);
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        int          lat;
        logic [31:0] c, f;
        logic [31:0] c0, f0;
        bit          moved;

        n_chk         = 0;
        n_pass        = 0;
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_op     = 4'b0000;
        ifc.in_a      = '0;
        ifc.in_b      = '0;
        ifc.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, ifc.in_ready}, 1);
        check("rst_out_valid", {31'd0, ifc.out_valid}, 0);
        check("rst_out_c",     {12'd0, ifc.out_c}, 0);
        check("rst_flags",     {27'd0, ifc.out_flags}, 0);
        @(negedge clk);
        rst = 1'b0;

        vec("div_1_2",   4'b0011, 16'h3E00, 16'h4000, 'h3C000, 'b00000, 18);
        vec("div_1_3",   4'b0011, 16'h3E00, 16'h4100, 'h3AAAA, 'b01000, 18);
        vec("div_m1_2",  4'b0011, 16'hBE00, 16'h4000, 'hBC000, 'b00000, 18);
        vec("x_div_0",   4'b0011, 16'h3E00, 16'h0000, 'h7E000, 'b00001, 2);
        vec("z_div_z",   4'b0011, 16'h8000, 16'h0000, 'h7F000, 'b10000, 2);
        vec("inf_inf",   4'b0011, 16'h7E00, 16'h7E00, 'h7F000, 'b10000, 2);
        vec("ovf",       4'b0011, 16'h7C00, 16'h0200, 'h7E000, 'b01100, 18);
        vec("unf",       4'b0011, 16'h0200, 16'h7C00, 'h00000, 'b01010, 18);

        // Backpressure: result held with out_ready low
        do_op(4'b0011, 16'h4000, 16'h3E00, 1'b0, lat, c0, f0);
        check("bp_c", c0, 'h40000);
        check("bp_flags", f0, 0);
        moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if ({12'd0, ifc.out_c} != c0 || {27'd0, ifc.out_flags} != f0 || !ifc.out_valid)
                moved = 1'b1;
        end
        check("bp_stable",   {31'd0, moved}, 0);
        check("bp_in_ready", {31'd0, ifc.in_ready}, 0);
        @(negedge clk);
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        check("pop_in_ready",  {31'd0, ifc.in_ready}, 1);
        check("pop_out_valid", {31'd0, ifc.out_valid}, 0);
        check("pop_flags",     {27'd0, ifc.out_flags}, 0);
        vec("nop", 4'b0001, 16'h3E00, 16'h4100, 'h00000, 'b00000, 2);

        // Reset during the mantissa iterations
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_op    = 4'b0011;
        ifc.in_a     = 16'h3E00;
        ifc.in_b     = 16'h4100;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", {31'd0, ifc.out_valid}, 0);
        check("mid_rst_in_ready",  {31'd0, ifc.in_ready}, 1);
        check("mid_rst_out_c",     {12'd0, ifc.out_c}, 0);
        @(negedge clk);
        rst = 1'b0;
        vec("post_rst", 4'b0011, 16'h3E00, 16'h4100, 'h3AAAA, 'b01000, 18);

        // Nothing further may appear after the pop
        do_op(4'b0011, 16'h3E00, 16'h4000, 1'b1, lat, c, f);
        check("last_c", c, 'h3C000);
        repeat (3) @(posedge clk);
        #1;
        check("idle_out_valid", {31'd0, ifc.out_valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
